mc_control: RTL and testbench

Multicycle successor to the single-cycle opcode decoder. It sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same control fields (mem_read, mem_write, mem_to_reg, reg_write, alu_op, alu_op_imm) per state. It adds a memory request/ready handshake, in-block branch resolution, a memory timeout and a retired-instruction counter. It sits between the instruction register/ALU flags and the shared-memory datapath.

---
 rtl/mc_control_pkg.sv | 152 +++++++++++++++
 rtl/mc_control_mem_wait.sv | 31 +++
 rtl/mc_control.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode values, control-field encodings and opcode classification helpers.
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b111111;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;

    // alu_op: add (address), sub (compare), funct field, immediate sub-op
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_ADD  = 3'b001;
    localparam logic [2:0] IMM_SUB  = 3'b010;
    localparam logic [2:0] IMM_AND  = 3'b011;
    localparam logic [2:0] IMM_OR   = 3'b100;
    localparam logic [2:0] IMM_SLT  = 3'b101;
    localparam logic [2:0] IMM_LUI  = 3'b110;

    // mem_read: bit 2 = enable, bits 1:0 = size (10 word, 01 half, 00 byte)
    localparam logic [2:0] MEM_RD_NONE = 3'b000;
    localparam logic [2:0] MEM_RD_WORD = 3'b110;
    localparam logic [2:0] MEM_RD_HALF = 3'b101;
    localparam logic [2:0] MEM_RD_BYTE = 3'b100;

    localparam logic [1:0] MEM_WR_NONE = 2'b00;
    localparam logic [1:0] MEM_WR_WORD = 2'b11;
    localparam logic [1:0] MEM_WR_HALF = 2'b10;
    localparam logic [1:0] MEM_WR_BYTE = 2'b01;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b11;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [2:0] alu_op_imm;
        logic       alu_src;
        logic       reg_dst;
    } alu_ctrl_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LW, OP_LH, OP_LB: is_load = 1'b1;
            default:             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SW, OP_SH, OP_SB: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI,
            OP_ORI, OP_SLTI, OP_LUI:  is_alu = 1'b1;
            default:                  is_alu = 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_BGEZ: is_branch = 1'b1;
            default:                 is_branch = 1'b0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        case (op)
            OP_J, OP_JAL: is_jump = 1'b1;
            default:      is_jump = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] load_width(input logic [5:0] op);
        case (op)
            OP_LW:   load_width = MEM_RD_WORD;
            OP_LH:   load_width = MEM_RD_HALF;
            OP_LB:   load_width = MEM_RD_BYTE;
            default: load_width = MEM_RD_NONE;
        endcase
    endfunction

    function automatic logic [1:0] store_width(input logic [5:0] op);
        case (op)
            OP_SW:   store_width = MEM_WR_WORD;
            OP_SH:   store_width = MEM_WR_HALF;
            OP_SB:   store_width = MEM_WR_BYTE;
            default: store_width = MEM_WR_NONE;
        endcase
    endfunction

    // ALU-side decode, identical to the single-cycle decoder's fields
    function automatic alu_ctrl_t alu_ctrl(input logic [5:0] op);
        case (op)
            OP_RTYPE: alu_ctrl = '{ALU_OP_FUNCT, IMM_NONE, 1'b0, 1'b1};
            OP_ADDI:  alu_ctrl = '{ALU_OP_IMM,   IMM_ADD,  1'b1, 1'b0};
            OP_SUBI:  alu_ctrl = '{ALU_OP_IMM,   IMM_SUB,  1'b1, 1'b0};
            OP_ANDI:  alu_ctrl = '{ALU_OP_IMM,   IMM_AND,  1'b1, 1'b0};
            OP_ORI:   alu_ctrl = '{ALU_OP_IMM,   IMM_OR,   1'b1, 1'b0};
            OP_SLTI:  alu_ctrl = '{ALU_OP_IMM,   IMM_SLT,  1'b1, 1'b0};
            OP_LUI:   alu_ctrl = '{ALU_OP_IMM,   IMM_LUI,  1'b1, 1'b0};
            OP_LW, OP_LH, OP_LB,
            OP_SW, OP_SH, OP_SB:
                      alu_ctrl = '{ALU_OP_ADD,   IMM_NONE, 1'b1, 1'b0};
            OP_BEQ, OP_BNE, OP_BGEZ:
                      alu_ctrl = '{ALU_OP_SUB,   IMM_NONE, 1'b0, 1'b0};
            default:  alu_ctrl = '{ALU_OP_ADD,   IMM_NONE, 1'b0, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/mc_control_mem_wait.sv
// Memory wait counter: counts cycles a request waits for mem_ready and
// flags a timeout on the MEM_TIMEOUT-th waiting cycle. i_start is held high
// whenever no request is outstanding, so every request begins from zero.
module mc_mem_wait #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int W = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // ready arriving on the threshold cycle wins over the timeout
    assign o_timeout = !i_start && !i_ready && (r_cnt == LIMIT);

    // wait counter: cleared when idle or when the request resolves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_start || i_ready || o_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS controller: sequences FETCH/DECODE/EXEC/MEM/WB with a
// memory handshake, branch resolution, timeout and retired-instruction count.
// Optional feature macro: MC_CTRL_TRAP_EN (illegal opcode / timeout -> TRAP).
module mc_control
    import mc_control_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                alu_neg,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_source,
    output logic                reg_dst,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic [2:0]          alu_op_imm,
    output logic [2:0]          mem_read,
    output logic [1:0]          mem_write,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          reg_write,
    output logic [3:0]          state_o,
    output logic                bus_err,
    output logic                trap,
    input  logic                trap_ack,
    output logic [CNT_W-1:0]    instr_count
);
`ifdef MC_CTRL_TRAP_EN
    localparam state_t FAULT_DEST      = S_TRAP;
    localparam logic   ILLEGAL_RETIRES = 1'b0;
`else
    localparam state_t FAULT_DEST      = S_FETCH;
    localparam logic   ILLEGAL_RETIRES = 1'b1;
    logic w_unused_trap_ack;
    assign w_unused_trap_ack = trap_ack;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic [CNT_W-1:0]    r_count;
    logic [5:0]          w_op;
    alu_ctrl_t           w_ctrl;
    logic                w_retire;
    logic                w_ir_load;
    logic                w_taken;
    logic                w_timeout;
    logic                w_wait_start;

    assign w_op         = 6'(r_opcode);
    assign w_ctrl       = alu_ctrl(w_op);
    assign w_taken      = ((w_op == OP_BEQ)  &&  alu_zero) ||
                          ((w_op == OP_BNE)  && !alu_zero) ||
                          ((w_op == OP_BGEZ) && !alu_neg);
    assign w_wait_start = (r_state != S_FETCH) && (r_state != S_MEM);
    assign bus_err      = w_timeout;
    assign state_o      = r_state;
    assign instr_count  = r_count;

    mc_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_wait_start),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // opcode latch, loaded together with the instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
        end else if (w_ir_load) begin
            r_opcode <= opcode;
        end else begin
            r_opcode <= r_opcode;
        end
    end

    // retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // next-state and Moore control outputs
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_ir_load  = 1'b0;
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PC_SRC_PC4;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_OP_ADD;
        alu_op_imm = IMM_NONE;
        mem_read   = MEM_RD_NONE;
        mem_write  = MEM_WR_NONE;
        mem_to_reg = M2R_ALU;
        reg_write  = RW_NONE;
        trap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_timeout) begin
                    w_next = FAULT_DEST;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_alu(w_op) || is_load(w_op) || is_store(w_op)) begin
                    w_next = S_EXEC;
                end else if (is_branch(w_op)) begin
                    w_next = S_BRANCH;
                end else if (is_jump(w_op)) begin
                    w_next = S_JUMP;
                end else begin
                    w_next   = FAULT_DEST;
                    w_retire = ILLEGAL_RETIRES;
                end
            end
            S_EXEC: begin
                {alu_op, alu_op_imm, alu_src, reg_dst} = w_ctrl;
                if (is_load(w_op) || is_store(w_op)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                {alu_op, alu_op_imm, alu_src, reg_dst} = w_ctrl;
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_read  = load_width(w_op);
                mem_write = store_width(w_op);
                if (mem_ready) begin
                    if (is_load(w_op)) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = FAULT_DEST;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                {alu_op, alu_op_imm, alu_src, reg_dst} = w_ctrl;
                reg_write  = RW_WRITE;
                mem_to_reg = is_load(w_op) ? M2R_MEM : M2R_ALU;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                {alu_op, alu_op_imm, alu_src, reg_dst} = w_ctrl;
                if (w_taken) begin
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_BRANCH;
                end else begin
                    pc_write  = 1'b0;
                end
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                if (w_op == OP_JAL) begin
                    reg_write  = RW_WRITE;
                    mem_to_reg = M2R_PC4;
                end else begin
                    reg_write  = RW_NONE;
                end
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                trap = 1'b1;
                if (trap_ack) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_TRAP;
                end
`else
                w_next = S_FETCH;
`endif
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: table of instructions with expected
// per-instruction signatures (scoreboard queue), plus hand sequences for
// timeout, illegal opcode and reset during a memory access.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode = 6'b000000;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic        mem_ready = 1'b0;
    logic        trap_ack = 1'b0;
    logic        mem_req, iord, ir_write, pc_write, reg_dst, alu_src, bus_err, trap;
    logic [1:0]  pc_source, alu_op, mem_write, mem_to_reg, reg_write;
    logic [2:0]  alu_op_imm, mem_read;
    logic [3:0]  state_o;
    logic [3:0]  instr_count;
    logic [23:0] outs;

    int total = 0;
    int bad = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    mc_control #(.OPCODE_W(6), .MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .mem_ready(mem_ready), .mem_req(mem_req),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .reg_dst(reg_dst), .alu_src(alu_src),
        .alu_op(alu_op), .alu_op_imm(alu_op_imm), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .state_o(state_o), .bus_err(bus_err), .trap(trap), .trap_ack(trap_ack),
        .instr_count(instr_count)
    );

    assign outs = {mem_req, iord, ir_write, pc_write, pc_source, reg_dst, alu_src,
                   alu_op, alu_op_imm, mem_read, mem_write, mem_to_reg, reg_write,
                   bus_err, trap};

    typedef struct {
        int         cycles;
        logic [1:0] alu_op;
        logic [2:0] imm;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] mem_read;
        logic [1:0] mem_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_write;
        logic [1:0] pc_source;
        int         pc_w;
        int         req;
    } res_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       neg;
        int         mem_wait;
        logic       retire;
        res_t       exp;
    } vec_t;

`ifdef MC_CTRL_TRAP_EN
    localparam int NV = 15;
`else
    localparam int NV = 16;
`endif

    vec_t tbl[NV];
    res_t sb_q[$];

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    function automatic bit res_eq(input res_t a, input res_t b);
        return a.cycles == b.cycles && a.alu_op === b.alu_op && a.imm === b.imm &&
               a.alu_src === b.alu_src && a.reg_dst === b.reg_dst &&
               a.mem_read === b.mem_read && a.mem_write === b.mem_write &&
               a.mem_to_reg === b.mem_to_reg && a.reg_write === b.reg_write &&
               a.pc_source === b.pc_source && a.pc_w == b.pc_w && a.req == b.req;
    endfunction

    function automatic string res_str(input res_t r);
        return $sformatf("cyc=%0d aop=%b imm=%b src=%b dst=%b rd=%b wr=%b m2r=%b rw=%b pcs=%b pcw=%0d req=%0d",
                         r.cycles, r.alu_op, r.imm, r.alu_src, r.reg_dst, r.mem_read,
                         r.mem_write, r.mem_to_reg, r.reg_write, r.pc_source, r.pc_w, r.req);
    endfunction

    // OR-accumulate the control fields seen during one instruction
    task automatic acc(inout res_t r);
        r.cycles++;
        r.alu_op     |= alu_op;
        r.imm        |= alu_op_imm;
        r.alu_src    |= alu_src;
        r.reg_dst    |= reg_dst;
        r.mem_read   |= mem_read;
        r.mem_write  |= mem_write;
        r.mem_to_reg |= mem_to_reg;
        r.reg_write  |= reg_write;
        r.pc_source  |= pc_source;
        if (pc_write) r.pc_w++;
        if (mem_req)  r.req++;
    endtask

    task automatic wait_fetch(input string name);
        int k = 0;
        while (state_o != 4'd1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check1(name, 32'(state_o), 32'd1);
    endtask

    // Starts at a negedge with the DUT in FETCH; ends at the next FETCH negedge
    task automatic run_vec(input vec_t v, input string name);
        res_t r = '{default: 0};
        res_t e;
        int   mc = 0;
        bit   done = 1'b0;
        logic [3:0] st;
        sb_q.push_back(v.exp);
        if (v.retire) exp_count++;
        opcode = v.op; alu_zero = v.zero; alu_neg = v.neg; mem_ready = 1'b1;
        #1;
        acc(r);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            st = state_o;
            if (st == 4'd1 || st == 4'd8 || st == 4'd0) begin
                done = 1'b1;
            end else begin
                if (st == 4'd4) begin
                    mem_ready = (mc == v.mem_wait);
                    mc++;
                end else begin
                    mem_ready = 1'b1;
                end
                #1;
                acc(r);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s bound: instruction did not return to FETCH", name);
        end
        e = sb_q.pop_front();
        total++;
        if (!res_eq(r, e)) begin
            bad++;
            $display("FAIL %s: got %s required %s", name, res_str(r), res_str(e));
        end
        check1({name, " count"}, 32'(instr_count), 32'(exp_count % 16));
    endtask

    task automatic timeout_seq();
        int first = 0;
        int nerr = 0;
        opcode = 6'b001000; mem_ready = 1'b0;
        for (int c = 1; c <= 20 && first == 0; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (bus_err) begin
                nerr++;
                first = c;
            end
        end
        check1("timeout cycle", 32'(first), 32'd16);
        @(negedge clk);
`ifdef MC_CTRL_TRAP_EN
        check1("timeout trap state", 32'(state_o), 32'd8);
        check1("trap held", 32'(trap), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (bus_err) nerr++;
        end
        check1("trap waits ack", 32'(state_o), 32'd8);
        trap_ack = 1'b1;
        @(negedge clk);
        check1("trap exit", 32'(state_o), 32'd1);
        check1("trap cleared", 32'(trap), 32'd0);
        trap_ack = 1'b0;
`else
        check1("timeout restart", 32'(state_o), 32'd1);
        check1("trap tied", 32'(trap), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (bus_err) nerr++;
        end
`endif
        check1("bus_err pulses", 32'(nerr), 32'd1);
        check1("timeout count", 32'(instr_count), 32'(exp_count % 16));
    endtask

`ifdef MC_CTRL_TRAP_EN
    task automatic illegal_trap_seq();
        opcode = 6'b110000; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("illegal trap state", 32'(state_o), 32'd8);
        check1("illegal trap out", 32'(trap), 32'd1);
        trap_ack = 1'b1;
        @(negedge clk);
        check1("illegal trap exit", 32'(state_o), 32'd1);
        trap_ack = 1'b0;
        check1("illegal count", 32'(instr_count), 32'(exp_count % 16));
    endtask
`endif

    task automatic reset_in_mem_seq();
        int k = 0;
        opcode = 6'b100011; mem_ready = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (state_o != 4'd4 && k < 10);
        check1("reach MEM", 32'(state_o), 32'd4);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check1("mid reset state", 32'(state_o), 32'd0);
        check1("mid reset outs", 32'(outs), 32'd0);
        check1("mid reset count", 32'(instr_count), 32'd0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch("restart after reset");
    endtask

    initial begin
        //        op         z     n     w  ret   cyc aop    imm     src   dst   rd      wr     m2r    rw     pcs   pcw req
        tbl[0]  = '{6'b001000, 1'b0, 1'b0, 0, 1'b1, '{4, 2'b11, 3'b001, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1}};
        tbl[1]  = '{6'b100011, 1'b0, 1'b0, 3, 1'b1, '{8, 2'b00, 3'b000, 1'b1, 1'b0, 3'b110, 2'b00, 2'b01, 2'b01, 2'b00, 1, 5}};
        tbl[2]  = '{6'b000100, 1'b1, 1'b0, 0, 1'b1, '{3, 2'b01, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2, 1}};
        tbl[3]  = '{6'b000100, 1'b0, 1'b0, 0, 1'b1, '{3, 2'b01, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1}};
        tbl[4]  = '{6'b000001, 1'b0, 1'b0, 0, 1'b1, '{3, 2'b01, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2, 1}};
        tbl[5]  = '{6'b000001, 1'b0, 1'b1, 0, 1'b1, '{3, 2'b01, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1}};
        tbl[6]  = '{6'b000011, 1'b0, 1'b0, 0, 1'b1, '{3, 2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b11, 2'b01, 2'b10, 2, 1}};
        tbl[7]  = '{6'b101011, 1'b0, 1'b0, 0, 1'b1, '{4, 2'b00, 3'b000, 1'b1, 1'b0, 3'b000, 2'b11, 2'b00, 2'b00, 2'b00, 1, 2}};
        tbl[8]  = '{6'b000000, 1'b0, 1'b0, 0, 1'b1, '{4, 2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1}};
        tbl[9]  = '{6'b100000, 1'b0, 1'b0, 1, 1'b1, '{6, 2'b00, 3'b000, 1'b1, 1'b0, 3'b100, 2'b00, 2'b01, 2'b01, 2'b00, 1, 3}};
        tbl[10] = '{6'b101001, 1'b0, 1'b0, 0, 1'b1, '{4, 2'b00, 3'b000, 1'b1, 1'b0, 3'b000, 2'b10, 2'b00, 2'b00, 2'b00, 1, 2}};
        tbl[11] = '{6'b000101, 1'b0, 1'b0, 0, 1'b1, '{3, 2'b01, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 2, 1}};
        tbl[12] = '{6'b000010, 1'b0, 1'b0, 0, 1'b1, '{3, 2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 2, 1}};
        tbl[13] = '{6'b001111, 1'b0, 1'b0, 0, 1'b1, '{4, 2'b11, 3'b110, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1}};
        tbl[14] = '{6'b111111, 1'b0, 1'b0, 0, 1'b1, '{4, 2'b11, 3'b010, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1}};
`ifndef MC_CTRL_TRAP_EN
        tbl[15] = '{6'b110000, 1'b0, 1'b0, 0, 1'b1, '{2, 2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1}};
`endif

        // reset held: everything at zero even with mem_ready high
        mem_ready = 1'b1;
        opcode = 6'b001000;
        #1 rst_n = 1'b0;
        #12;
        check1("reset state", 32'(state_o), 32'd0);
        check1("reset outs", 32'(outs), 32'd0);
        check1("reset count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch("first fetch");

        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("p0 vec%0d", i));
        timeout_seq();
`ifdef MC_CTRL_TRAP_EN
        illegal_trap_seq();
`endif
        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("p1 vec%0d", i));
        reset_in_mem_seq();
        run_vec(tbl[0], "addi after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
